// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and wait-state controller sharing one req/ack data memory
// between the CPU data port and a debug/DMA requester, with CPU stall and access timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam logic CPU = 1'b0, DBG = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d, last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        m_req_q, m_req_d, m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic        dbg_ack_q, dbg_ack_d, bus_err_q, bus_err_d;
    logic        grant, timed_out;
    logic [31:0] rd_val;

    // on contention the requester not served last wins; a lone request always wins
    assign grant     = (cpu_req && dbg_req) ? ~last_q : dbg_req;
    assign timed_out = cnt_q == 8'(TIMEOUT);
    assign rd_val    = m_ack ? m_rdata : 32'd0;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_ack_d   = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: if (cpu_req || dbg_req) begin
                owner_d   = grant;
                m_req_d   = 1'b1;
                m_we_d    = grant ? dbg_we : cpu_we;
                m_addr_d  = grant ? dbg_addr : cpu_addr;
                m_wdata_d = grant ? dbg_wdata : cpu_wdata;
                cnt_d     = 8'd0;
                state_d   = BUSY;
            end
            BUSY: if (m_ack || timed_out) begin
                m_req_d   = 1'b0;
                state_d   = DONE;
                dbg_ack_d = owner_q == DBG;
                bus_err_d = ~m_ack;
                if (!m_we_q && owner_q == DBG) dbg_rdata_d = rd_val;
                if (!m_we_q && owner_q == CPU) cpu_rdata_d = rd_val;
            end else begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= CPU;
            last_q      <= DBG;
            cnt_q       <= 8'd0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 32'd0;
            cpu_rdata_q <= 32'd0;
            dbg_rdata_q <= 32'd0;
            dbg_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_ack_q   <= dbg_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_stall = cpu_req & ~(state_q == DONE && owner_q == CPU);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign bus_err   = bus_err_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
endmodule
